// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU operand stage and the ALU.
// Holds default widths, opcode values and the operand stage state encoding.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int OP_W_DEF  = 3;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } opnd_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode to one-hot unit enable, gated by valid.
// Ports: valid, op[OP_W] in; sel[2**OP_W] out (all zero when !valid).
module alu_op_decode #(
    parameter int OP_W = 3
) (
    input  logic                 valid,
    input  logic [OP_W-1:0]      op,
    output logic [2**OP_W-1:0]   sel
);

    always_comb begin
        sel = '0;
        if (valid) begin
            sel[op] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered operand stage in front of the ALU.
// 2-entry skid buffer, registered in_ready, one-hot unit select.
// Ports: clk, reset (sync, high), flush; in_valid/in_ready/in_op/in_a/in_b;
// out_valid/out_ready/out_op/out_a/out_b/out_sel;
// stall_cnt[32] only when ALU_OPND_STALL_CNT_EN is defined.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      out_op,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
`ifdef ALU_OPND_STALL_CNT_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic [2**OP_W-1:0]   out_sel
);

    opnd_state_e state_q;
    opnd_state_e state_n;

    logic             in_ready_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    logic [OP_W-1:0]  main_op;
    logic [WIDTH-1:0] main_a;
    logic [WIDTH-1:0] main_b;
    logic [OP_W-1:0]  skid_op;
    logic [WIDTH-1:0] skid_a;
    logic [WIDTH-1:0] skid_b;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_n        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_n      = FULL;
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    state_n   = SKID;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_n = EMPTY;
                end
            end
            SKID: begin
                // in_ready is low here, so only the drain matters
                if (out_xfer) begin
                    state_n        = FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
        // flush drops everything, including a same-cycle input
        if (flush) begin
            state_n        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            // ready is a pure register: low only while skid holds data
            in_ready_q <= (state_n != SKID);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_op <= '0;
            main_a  <= '0;
            main_b  <= '0;
        end else if (load_main_in) begin
            main_op <= in_op;
            main_a  <= in_a;
            main_b  <= in_b;
        end else if (load_main_skid) begin
            main_op <= skid_op;
            main_a  <= skid_a;
            main_b  <= skid_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_op <= '0;
            skid_a  <= '0;
            skid_b  <= '0;
        end else if (load_skid) begin
            skid_op <= in_op;
            skid_a  <= in_a;
            skid_b  <= in_b;
        end
    end

    assign out_op = main_op;
    assign out_a  = main_a;
    assign out_b  = main_b;

    alu_op_decode #(
        .OP_W (OP_W)
    ) u_dec (
        .valid (out_valid),
        .op    (main_op),
        .sel   (out_sel)
    );

`ifdef ALU_OPND_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed self-checking bench for alu_operand_stage.
// Define ALU_OPND_STALL_CNT_EN to also exercise the stall counter.
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [7:0]  out_sel;
`ifdef ALU_OPND_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int tests;
    int fails;

    alu_operand_stage #(
        .WIDTH (32),
        .OP_W  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b),
`ifdef ALU_OPND_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // reset state
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single entry, 1-cycle latency
        in_valid  = 1'b1;
        in_op     = OP_AND;
        in_a      = 32'd11;
        in_b      = 32'd1;
        out_ready = 1'b1;
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_a", out_a, 32'd11);
        chk("t1_b", out_b, 32'd1);
        chk("t1_sel", 32'(out_sel), 32'h01);
        chk("t1_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // back-to-back streaming, no bubbles
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_op    = 3'(i);
            in_a     = 32'(i);
            in_b     = ~32'(i);
            step();
            chk("t2_valid", 32'(out_valid), 32'd1);
            chk("t2_a", out_a, 32'(i));
            chk("t2_b", out_b, ~32'(i));
            chk("t2_sel", 32'(out_sel), 32'd1 << i);
            chk("t2_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("t2_drain", 32'(out_valid), 32'd0);

        // backpressure fills the skid, then drains in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_ADD;
        in_a      = 32'hFFFF_FFFF;
        in_b      = 32'd2;
        step();
        chk("t3_c1_a", out_a, 32'hFFFF_FFFF);
        chk("t3_c1_ready", 32'(in_ready), 32'd1);
        in_op = OP_SUB;
        in_a  = 32'h075B_CD15;
        in_b  = 32'd3;
        step();
        chk("t3_c2_ready", 32'(in_ready), 32'd0);
        chk("t3_c2_a", out_a, 32'hFFFF_FFFF);
        in_op = OP_XOR;
        in_a  = 32'd0;
        in_b  = 32'd4;
        step();
        chk("t3_c3_ready", 32'(in_ready), 32'd0);
        chk("t3_c3_a", out_a, 32'hFFFF_FFFF);
        chk("t3_c3_sel", 32'(out_sel), 32'h04);
        chk("t3_c3_op", 32'(out_op), 32'(OP_ADD));
        out_ready = 1'b1;
        step();
        chk("t3_d1_a", out_a, 32'h075B_CD15);
        chk("t3_d1_sel", 32'(out_sel), 32'h08);
        chk("t3_d1_ready", 32'(in_ready), 32'd1);
        step();
        chk("t3_d2_valid", 32'(out_valid), 32'd1);
        chk("t3_d2_a", out_a, 32'd0);
        chk("t3_d2_b", out_b, 32'd4);
        chk("t3_d2_sel", 32'(out_sel), 32'h10);
        in_valid = 1'b0;
        step();
        chk("t3_empty", 32'(out_valid), 32'd0);

        // flush from SKID discards a same-cycle input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_SLT;
        in_a      = 32'd201;
        step();
        in_a = 32'd202;
        step();
        chk("t4_skid_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        in_a  = 32'd101;
        step();
        chk("t4_fl_valid", 32'(out_valid), 32'd0);
        chk("t4_fl_ready", 32'(in_ready), 32'd1);
        chk("t4_fl_sel", 32'(out_sel), 32'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t4_no_101", 32'(out_valid), 32'd0);

        // reset while in SKID
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_SLL;
        in_a      = 32'd301;
        step();
        in_a = 32'd302;
        step();
        chk("t5_skid_ready", 32'(in_ready), 32'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_sel", 32'(out_sel), 32'd0);
        chk("t5_rst_ready", 32'(in_ready), 32'd0);
        chk("t5_rst_a", out_a, 32'd0);
`ifdef ALU_OPND_STALL_CNT_EN
        chk("t5_rst_cnt", stall_cnt, 32'd0);
`endif
        reset = 1'b0;
        step();
        chk("t5_post_ready", 32'(in_ready), 32'd1);
        chk("t5_post_valid", 32'(out_valid), 32'd0);

`ifdef ALU_OPND_STALL_CNT_EN
        // five stalled cycles, flush keeps count, reset clears
        in_valid = 1'b1;
        in_op    = OP_SRL;
        in_a     = 32'd5;
        step();
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_cnt0", stall_cnt, 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        chk("t6_cnt5", stall_cnt, 32'd5);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_fl_cnt", stall_cnt, 32'd5);
        chk("t6_fl_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_cnt", stall_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
